nco_phase_acc: RTL

Numerically controlled phase accumulator that sits directly upstream of the 8-bit sine lookup. It integrates a frequency tuning word (FTW) once per sample tick and adds a static phase offset. It presents the top 8 bits as a registered phase word to the sine LUT's 8-bit input. FTW updates arrive over a valid/ready handshake and apply either immediately or at the next phase wrap, which gives glitch-free frequency changes.

---
 rtl/nco_pkg.sv | 27 ++
 rtl/nco_phase_acc_if.sv | 33 +++
 rtl/nco_dither_lfsr.sv | 32 +++
 rtl/nco_phase_acc.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/nco_pkg.sv
// Shared definitions for the NCO phase accumulator slice.
//
// Contents:
//   NCO_ACC_W / NCO_PHASE_W    default accumulator and phase widths
//   LFSR_SEED / LFSR_TAPS      dither LFSR seed and Galois tap mask
//   UPD_IMMEDIATE/UPD_AT_WRAP  update_mode encodings
//   ftw_state_t                FTW handshake FSM states
//
// Optional feature macro: PHASE_DITHER_EN (uses the LFSR constants).
package nco_pkg;

    localparam int NCO_ACC_W   = 24;
    localparam int NCO_PHASE_W = 8;

    // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11 + 1
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam logic UPD_IMMEDIATE = 1'b0;
    localparam logic UPD_AT_WRAP   = 1'b1;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } ftw_state_t;

endpackage

// File: rtl/nco_phase_acc_if.sv
// Control/data bundle between the NCO phase accumulator and its driver.
//
// master modport: drives tick_en, sync_clr, ftw_in, ftw_valid, update_mode,
//                 phase_off; observes ftw_ready, phase_word, phase_valid,
//                 wrap_pulse.
// slave modport:  the accumulator side (directions mirrored).
interface nco_phase_acc_if
    import nco_pkg::*;
#(
    parameter int ACC_W   = NCO_ACC_W,
    parameter int PHASE_W = NCO_PHASE_W
);
    logic               tick_en;
    logic               sync_clr;
    logic [ACC_W-1:0]   ftw_in;
    logic               ftw_valid;
    logic               ftw_ready;
    logic               update_mode;
    logic [PHASE_W-1:0] phase_off;
    logic [PHASE_W-1:0] phase_word;
    logic               phase_valid;
    logic               wrap_pulse;

    modport master (
        output tick_en, sync_clr, ftw_in, ftw_valid, update_mode, phase_off,
        input  ftw_ready, phase_word, phase_valid, wrap_pulse
    );

    modport slave (
        input  tick_en, sync_clr, ftw_in, ftw_valid, update_mode, phase_off,
        output ftw_ready, phase_word, phase_valid, wrap_pulse
    );
endinterface

// File: rtl/nco_dither_lfsr.sv
// 16-bit Galois LFSR used to dither the phase truncation.
//
// Ports:
//   clk       system clock
//   rst_n     asynchronous active-low reset (loads LFSR_SEED)
//   adv       advance one step this cycle
//   lfsr_out  current LFSR state
//
// Only instantiated when PHASE_DITHER_EN is defined.
module nco_dither_lfsr
    import nco_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        adv,
    output logic [15:0] lfsr_out
);

    logic [15:0] r_lfsr;

    // Shift right; the bit falling out of bit 0 folds back through the taps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= LFSR_SEED;
        end else if (adv) begin
            r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? LFSR_TAPS : 16'h0000);
        end
    end

    assign lfsr_out = r_lfsr;

endmodule

// File: rtl/nco_phase_acc.sv
// Numerically controlled phase accumulator feeding an 8-bit sine LUT.
//
// Integrates the active tuning word on every sample tick, adds a phase
// offset to the top PHASE_W bits and registers the result as phase_word.
// New tuning words arrive over a valid/ready handshake and are applied
// either immediately or at the next accumulator wrap.
//
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    nco_phase_acc_if.slave: tick_en, sync_clr, ftw_in, ftw_valid,
//          ftw_ready, update_mode, phase_off, phase_word, phase_valid,
//          wrap_pulse
//
// Parameters: ACC_W (>= 9), PHASE_W (8, LUT input width), FTW_RESET.
// Optional feature macro: PHASE_DITHER_EN adds LFSR dither to the output
// path before truncation; accumulator state and wrap_pulse are unaffected.
module nco_phase_acc
    import nco_pkg::*;
#(
    parameter int               ACC_W     = NCO_ACC_W,
    parameter int               PHASE_W   = NCO_PHASE_W,
    parameter logic [ACC_W-1:0] FTW_RESET = ACC_W'(24'h010000)
)
(
    input  logic              clk,
    input  logic              rst_n,
    nco_phase_acc_if.slave    bus
);

    logic [ACC_W-1:0]   r_acc;
    logic [ACC_W-1:0]   r_ftw_act;
    logic [ACC_W-1:0]   r_ftw_pend;
    logic [PHASE_W-1:0] r_phase_word;
    logic               r_phase_valid;
    logic               r_wrap_pulse;
    ftw_state_t         r_state;

    ftw_state_t         w_state_next;
    logic [ACC_W-1:0]   w_ftw_act_next;
    logic [ACC_W-1:0]   w_ftw_pend_next;
    logic [ACC_W:0]     w_sum;
    logic [ACC_W-1:0]   w_acc_next;
    logic               w_carry;
    logic [ACC_W-1:0]   w_out_acc;
    logic               w_adv;

    assign w_sum      = {1'b0, r_acc} + {1'b0, r_ftw_act};
    assign w_acc_next = w_sum[ACC_W-1:0];
    assign w_carry    = w_sum[ACC_W];
    // sync_clr overrides a tick, so a clearing cycle never counts as an advance
    assign w_adv      = bus.tick_en & ~bus.sync_clr;

`ifdef PHASE_DITHER_EN
    logic [15:0]      w_lfsr;
    logic [ACC_W-1:0] w_dither;

    nco_dither_lfsr u_dither (
        .clk      (clk),
        .rst_n    (rst_n),
        .adv      (bus.tick_en),
        .lfsr_out (w_lfsr)
    );

    // Dither only the bits that truncation throws away
    always_comb begin
        w_dither = '0;
        for (int i = 0; i < ACC_W - PHASE_W; i++) begin
            if (i < 16) w_dither[i] = w_lfsr[i];
        end
    end

    assign w_out_acc = w_acc_next + w_dither;
`else
    assign w_out_acc = w_acc_next;
`endif

    // Accumulator and registered output path
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc         <= '0;
            r_phase_word  <= '0;
            r_phase_valid <= 1'b0;
            r_wrap_pulse  <= 1'b0;
        end else if (bus.sync_clr) begin
            r_acc         <= '0;
            r_phase_word  <= bus.phase_off;
            r_phase_valid <= 1'b1;
            r_wrap_pulse  <= 1'b0;
        end else if (bus.tick_en) begin
            r_acc         <= w_acc_next;
            r_phase_word  <= w_out_acc[ACC_W-1 -: PHASE_W] + bus.phase_off;
            r_phase_valid <= 1'b1;
            r_wrap_pulse  <= w_carry;
        end else begin
            r_phase_valid <= 1'b0;
            r_wrap_pulse  <= 1'b0;
        end
    end

    // FTW handshake state and tuning-word registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_ftw_act  <= FTW_RESET;
            r_ftw_pend <= '0;
        end else begin
            r_state    <= w_state_next;
            r_ftw_act  <= w_ftw_act_next;
            r_ftw_pend <= w_ftw_pend_next;
        end
    end

    // A deferred load only triggers from PENDING, so a handshake that lands
    // on a wrapping tick in IDLE waits for the following wrap. The wrapping
    // tick itself still integrates the old FTW because r_ftw_act is registered.
    always_comb begin
        w_state_next    = r_state;
        w_ftw_act_next  = r_ftw_act;
        w_ftw_pend_next = r_ftw_pend;
        unique case (r_state)
            ST_IDLE: begin
                if (bus.ftw_valid) begin
                    if (bus.update_mode == UPD_IMMEDIATE) begin
                        w_ftw_act_next = bus.ftw_in;
                    end else begin
                        w_ftw_pend_next = bus.ftw_in;
                        w_state_next    = ST_PENDING;
                    end
                end
            end
            ST_PENDING: begin
                if (w_adv && w_carry) begin
                    w_ftw_act_next = r_ftw_pend;
                    w_state_next   = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign bus.ftw_ready   = (r_state == ST_IDLE);
    assign bus.phase_word  = r_phase_word;
    assign bus.phase_valid = r_phase_valid;
    assign bus.wrap_pulse  = r_wrap_pulse;

endmodule
